// File: rtl/vga_timing_if.sv
// Raster timing bundle between the VGA timing generator and its consumers.
// The generator is the master: it samples update and drives the raster signals.
interface vga_timing_if;
  logic       update;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_start;
  logic       tick;
  logic       overrun;

  modport master (
    input  update,
    output hcount, vcount, hsync, vsync, video_on, frame_start, tick, overrun
  );

  modport slave (
    output update,
    input  hcount, vcount, hsync, vsync, video_on, frame_start, tick, overrun
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing from the 25 MHz pixel clock, plus a frame-aligned
// tick derived from the asynchronous update toggle of the clock converter.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_timing_if.master   vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] h_q, v_q;
  logic [9:0] h_nxt, v_nxt;
  logic       hsync_q, vsync_q, video_on_q, frame_start_q, tick_q, overrun_q;
  logic       sync1_q, sync2_q, dly_q, pending_q;
  logic       update_evt;
  logic       at_issue;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    h_nxt = h_q + 10'd1;
    v_nxt = v_q;
    if (h_q == H_LAST) begin
      h_nxt = 10'd0;
      v_nxt = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    end
  end

  // Either edge of the resynchronised toggle is one update event.
  assign update_evt = sync2_q ^ dly_q;

  // Outputs are computed from the next counter values so that, once
  // registered, they describe the same pixel as hcount/vcount.
  assign at_issue = (h_nxt == 10'd0) && (v_nxt == V_VIS);

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= 10'd0;
      v_q           <= 10'd0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      tick_q        <= 1'b0;
      overrun_q     <= 1'b0;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      dly_q         <= 1'b0;
      pending_q     <= 1'b0;
    end else begin
      h_q           <= h_nxt;
      v_q           <= v_nxt;
      hsync_q       <= !((h_nxt >= HS_FIRST) && (h_nxt <= HS_LAST));
      vsync_q       <= !((v_nxt >= VS_FIRST) && (v_nxt <= VS_LAST));
      video_on_q    <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      frame_start_q <= (h_nxt == 10'd0) && (v_nxt == 10'd0);
      tick_q        <= at_issue && (pending_q || update_evt);

      sync1_q <= vga.update;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;

      // An event landing on the issue point is consumed by that tick.
      if (at_issue) begin
        pending_q <= 1'b0;
      end else if (update_evt) begin
        pending_q <= 1'b1;
        if (pending_q) overrun_q <= 1'b1;
      end
    end
  end

  assign vga.hcount      = h_q;
  assign vga.vcount      = v_q;
  assign vga.hsync       = hsync_q;
  assign vga.vsync       = vsync_q;
  assign vga.video_on    = video_on_q;
  assign vga.frame_start = frame_start_q;
  assign vga.tick        = tick_q;
  assign vga.overrun     = overrun_q;

endmodule
